// File: rtl/covid_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT branch codes into 30-bit frames of up to 15 codes and hands
// each frame downstream on a valid/ready handshake (full, flush or idle timeout).
module covid_nios2_qsys_0_oci_dct_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  dct_code,
  input  logic        code_valid,
  input  logic        trace_enable,
  input  logic        flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_THRESH = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [29:0] r_acc;
  logic [3:0]  r_acc_cnt;
  logic        r_flush_pend;
  logic [15:0] r_idle_cnt;
  logic        r_to_held;
  logic [29:0] r_buf;
  logic [3:0]  r_cnt;
  logic        r_frame_valid;
  logic        r_overflow;

  logic        w_out_free;
  logic        w_to_hit;
  logic        w_emit;
  logic        w_code_in;
  logic        w_accept;
  logic [29:0] w_slot_data;

  always_comb begin
    w_out_free  = !r_frame_valid || frame_ready;
    w_to_hit    = r_to_held || (TO_EN && (r_idle_cnt >= TO_THRESH));
    w_emit      = w_out_free && (r_acc_cnt != 4'd0) &&
                  ((r_acc_cnt == 4'd15) || r_flush_pend || w_to_hit);
    w_code_in   = code_valid && trace_enable;
    w_accept    = w_code_in && ((r_acc_cnt != 4'd15) || w_emit);
    // Unused slots are always zero, so OR-ing the shifted code writes slot acc_cnt.
    w_slot_data = {28'd0, dct_code} << {r_acc_cnt, 1'b0};
  end

  // NOTE: every register below updates with <= so all next-state terms see
  // start-of-cycle values, which is exactly what the emit/accept equations assume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc         <= '0;
      r_acc_cnt     <= '0;
      r_flush_pend  <= 1'b0;
      r_idle_cnt    <= '0;
      r_to_held     <= 1'b0;
      r_buf         <= '0;
      r_cnt         <= '0;
      r_frame_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_emit) begin
        r_buf         <= r_acc;
        r_cnt         <= r_acc_cnt;
        r_frame_valid <= 1'b1;
        r_acc         <= w_accept ? {28'd0, dct_code} : 30'd0;
        r_acc_cnt     <= w_accept ? 4'd1 : 4'd0;
      end else begin
        if (r_frame_valid && frame_ready) begin
          r_buf         <= '0;
          r_cnt         <= '0;
          r_frame_valid <= 1'b0;
        end
        if (w_accept) begin
          r_acc     <= r_acc | w_slot_data;
          r_acc_cnt <= r_acc_cnt + 4'd1;
        end
      end

      // A flush coinciding with an emit only sticks if it brought a new code.
      if (w_emit)
        r_flush_pend <= flush && w_accept;
      else if (flush && ((r_acc_cnt != 4'd0) || w_accept))
        r_flush_pend <= 1'b1;

      if (w_accept || (r_acc_cnt == 4'd0))
        r_idle_cnt <= '0;
      else if (r_idle_cnt != 16'hFFFF)
        r_idle_cnt <= r_idle_cnt + 16'd1;

      r_to_held <= !w_emit && w_to_hit && (r_acc_cnt != 4'd0);

      if (w_code_in && !w_accept)
        r_overflow <= 1'b1;
      else if (overflow_clr)
        r_overflow <= 1'b0;
    end
  end

  assign frame_valid = r_frame_valid;
  assign dct_buffer  = r_buf;
  assign dct_count   = r_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_covid_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: full frame, flush, back-pressure,
// timeout, flush at the full boundary and reset mid-frame.
module tb_covid_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  dct_code;
  logic        code_valid;
  logic        trace_enable;
  logic        flush;
  logic        frame_ready;
  logic        frame_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        overflow_clr;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  covid_nios2_qsys_0_oci_dct_packer #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dct_code     (dct_code),
    .code_valid   (code_valid),
    .trace_enable (trace_enable),
    .flush        (flush),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    reset_n      = 1'b0;
    dct_code     = 2'b00;
    code_valid   = 1'b0;
    trace_enable = 1'b1;
    flush        = 1'b0;
    frame_ready  = 1'b1;
    overflow_clr = 1'b0;
    #12;
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_buf",   {2'd0, dct_buffer},   32'd0);
    check("rst_cnt",   {28'd0, dct_count},   32'd0);
    check("rst_ovf",   {31'd0, overflow},    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Full frame: codes 01,10,11 repeating -> 0x39E79E79.
    for (int i = 0; i < 15; i++) begin
      code_valid = 1'b1;
      dct_code   = 2'((i % 3) + 1);
      step();
    end
    code_valid = 1'b0;
    check("full_not_yet", {31'd0, frame_valid}, 32'd0);
    step();
    check("full_valid", {31'd0, frame_valid}, 32'd1);
    check("full_cnt",   {28'd0, dct_count},   32'd15);
    check("full_buf",   {2'd0, dct_buffer},   32'h39E7_9E79);
    check("full_ovf",   {31'd0, overflow},    32'd0);
    step();
    check("full_pop_valid", {31'd0, frame_valid}, 32'd0);
    check("full_pop_cnt",   {28'd0, dct_count},   32'd0);

    // Flush of a partial frame: 11,10,01 -> 0x1B.
    code_valid = 1'b1; dct_code = 2'b11; step();
    dct_code = 2'b10; step();
    dct_code = 2'b01; step();
    code_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_not_yet", {31'd0, frame_valid}, 32'd0);
    step();
    check("flush_valid", {31'd0, frame_valid}, 32'd1);
    check("flush_cnt",   {28'd0, dct_count},   32'd3);
    check("flush_buf",   {2'd0, dct_buffer},   32'h0000_001B);
    step();
    check("flush_pop", {31'd0, frame_valid}, 32'd0);

    // Back-pressure: 15 x 01, 15 x 10, then an 11 that must be dropped.
    frame_ready = 1'b0;
    for (int i = 0; i < 31; i++) begin
      code_valid = 1'b1;
      dct_code   = (i < 15) ? 2'b01 : ((i < 30) ? 2'b10 : 2'b11);
      step();
      if (i == 15) begin
        check("bp_f1_valid", {31'd0, frame_valid}, 32'd1);
        check("bp_f1_buf",   {2'd0, dct_buffer},   32'h1555_5555);
      end
      if (i == 29) check("bp_no_ovf_yet", {31'd0, overflow}, 32'd0);
    end
    code_valid = 1'b0;
    check("bp_ovf",       {31'd0, overflow},    32'd1);
    check("bp_f1_stable", {2'd0, dct_buffer},   32'h1555_5555);
    check("bp_f1_cnt",    {28'd0, dct_count},   32'd15);
    frame_ready = 1'b1;
    step();
    check("bp_f2_valid", {31'd0, frame_valid}, 32'd1);
    check("bp_f2_buf",   {2'd0, dct_buffer},   32'h2AAA_AAAA);
    check("bp_f2_cnt",   {28'd0, dct_count},   32'd15);
    step();
    check("bp_f2_pop", {31'd0, frame_valid}, 32'd0);
    check("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Timeout with TIMEOUT_CYCLES = 4: one code 10, no flush.
    code_valid = 1'b1; dct_code = 2'b10;
    step();
    code_valid = 1'b0;
    step(); step(); step();
    check("to_not_yet", {31'd0, frame_valid}, 32'd0);
    step();
    check("to_valid", {31'd0, frame_valid}, 32'd1);
    check("to_cnt",   {28'd0, dct_count},   32'd1);
    check("to_buf",   {2'd0, dct_buffer},   32'h0000_0002);
    step();

    // Flush together with the 15th code: exactly one 15-code frame.
    for (int i = 0; i < 15; i++) begin
      code_valid = 1'b1;
      dct_code   = 2'b11;
      flush      = (i == 14);
      step();
    end
    code_valid = 1'b0;
    flush      = 1'b0;
    step();
    check("fb_valid", {31'd0, frame_valid}, 32'd1);
    check("fb_cnt",   {28'd0, dct_count},   32'd15);
    check("fb_buf",   {2'd0, dct_buffer},   32'h3FFF_FFFF);
    step();
    step();
    check("fb_no_empty_valid", {31'd0, frame_valid}, 32'd0);
    check("fb_no_empty_cnt",   {28'd0, dct_count},   32'd0);

    // Reset mid-frame: a held frame plus 7 buffered codes are discarded.
    frame_ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      code_valid = 1'b1;
      dct_code   = 2'b01;
      step();
    end
    code_valid = 1'b0;
    check("pre_rst_valid", {31'd0, frame_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    check("mid_rst_buf",   {2'd0, dct_buffer},   32'd0);
    check("mid_rst_cnt",   {28'd0, dct_count},   32'd0);
    check("mid_rst_ovf",   {31'd0, overflow},    32'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    frame_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (frame_valid !== 1'b0) seen++;
    end
    check("post_rst_no_frame", 32'(seen), 32'd0);
    check("post_rst_ovf", {31'd0, overflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
